// File: rtl/i2c_glitch_filter_mc.sv
// Multi-channel glitch filter: synchronise, run-length qualify, strobe edges, count glitches.
// Latency: SYNC_STAGES + max(filt_len,1) edges from first sampling edge to out_filt.
// Backpressure: none; free-running, consumes a new sample every clock.
module i2c_glitch_filter_mc #(
    parameter int   NUM_CH      = 2,
    parameter int   SYNC_STAGES = 2,
    parameter int   CNT_W       = 4,
    parameter int   GCNT_W      = 8,
    parameter logic RESET_VAL   = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [CNT_W-1:0]         filt_len,
    input  logic                     clr_gcnt,
    input  logic [NUM_CH-1:0]        in_raw,
    output logic [NUM_CH-1:0]        out_filt,
    output logic [NUM_CH-1:0]        rise_pulse,
    output logic [NUM_CH-1:0]        fall_pulse,
    output logic [NUM_CH*GCNT_W-1:0] glitch_cnt
);

    localparam logic [GCNT_W-1:0] GCNT_MAX = '1;

    logic [SYNC_STAGES-1:0][NUM_CH-1:0] sync_q, sync_d;
    logic [NUM_CH-1:0]                  filt_q, filt_d;
    logic [NUM_CH-1:0]                  rise_q, rise_d;
    logic [NUM_CH-1:0]                  fall_q, fall_d;
    logic [NUM_CH-1:0][CNT_W-1:0]       cnt_q, cnt_d;
    logic [NUM_CH-1:0][GCNT_W-1:0]      gcnt_q, gcnt_d;

    // Effective length, widened by one bit so cnt + 1 can never wrap in the compare.
    logic [CNT_W:0] len_eff;
    logic [CNT_W:0] cnt_inc;
    logic           s_bit;

    // Next-state: synchroniser shift, per-channel qualifier, glitch accounting.
    always_comb begin
        sync_d  = sync_q;
        filt_d  = filt_q;
        rise_d  = '0;
        fall_d  = '0;
        cnt_d   = cnt_q;
        gcnt_d  = gcnt_q;
        cnt_inc = '0;
        s_bit   = 1'b0;
        len_eff = (filt_len == '0) ? {{CNT_W{1'b0}}, 1'b1} : {1'b0, filt_len};

        sync_d[0] = in_raw;
        for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_d[k] = sync_q[k-1];
        end

        for (int i = 0; i < NUM_CH; i++) begin
            s_bit   = sync_q[SYNC_STAGES-1][i];
            cnt_inc = {1'b0, cnt_q[i]} + {{CNT_W{1'b0}}, 1'b1};
            if (s_bit != filt_q[i]) begin
                if (cnt_inc >= len_eff) begin
                    filt_d[i] = s_bit;
                    cnt_d[i]  = '0;
                    rise_d[i] = s_bit;
                    fall_d[i] = ~s_bit;
                end else begin
                    cnt_d[i] = cnt_inc[CNT_W-1:0];
                end
            end else begin
                cnt_d[i] = '0;
                // A run that ended before qualifying was a glitch.
                if (cnt_q[i] != '0 && gcnt_q[i] != GCNT_MAX) begin
                    gcnt_d[i] = gcnt_q[i] + {{(GCNT_W-1){1'b0}}, 1'b1};
                end
            end
        end

        // Clear takes priority over a glitch detected in the same cycle.
        if (clr_gcnt) begin
            gcnt_d = '0;
        end
    end

    // State registers with synchronous reset to the idle bus level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {SYNC_STAGES{{NUM_CH{RESET_VAL}}}};
            filt_q <= {NUM_CH{RESET_VAL}};
            rise_q <= '0;
            fall_q <= '0;
            cnt_q  <= '0;
            gcnt_q <= '0;
        end else begin
            sync_q <= sync_d;
            filt_q <= filt_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            cnt_q  <= cnt_d;
            gcnt_q <= gcnt_d;
        end
    end

    assign out_filt   = filt_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;
    assign glitch_cnt = gcnt_q;

endmodule
